// File: rtl/speaker_sched.sv
// Two-requester note scheduler: alert (bit0) beats melody (bit1); each note plays, then a silent gap.
// Optional build macro SPEAKER_SCHED_PREEMPT_EN lets an alert abort a melody note in progress.
module speaker_sched #(
  parameter int TICK_DIV = 100000,
  parameter int DUR_W    = 12,
  parameter int GAP_MS   = 10
) (
  input  logic             clk_100mHz,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [5:0]       req_note0,
  input  logic [5:0]       req_note1,
  input  logic [DUR_W-1:0] req_dur0,
  input  logic [DUR_W-1:0] req_dur1,
  output logic [1:0]       req_ready,
  output logic [5:0]       note_out,
  output logic             note_on,
  output logic [1:0]       owner,
  output logic [1:0]       done
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W  = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
  localparam int CNT_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        ready_q, ready_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        done_q,  done_d;
  logic [5:0]        note_q,  note_d;
  logic [TICK_W-1:0] tick_q,  tick_d;
  logic [CNT_W-1:0]  ms_q,    ms_d;
  logic              xfer, tick_end, last_ms;

  // A zero duration still plays one millisecond.
  function automatic logic [CNT_W-1:0] dur_eff(input logic [DUR_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : CNT_W'(d);
  endfunction

  assign xfer     = |(req_valid & ready_q);
  assign tick_end = (tick_q == TICK_LAST);
  assign last_ms  = (ms_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    ready_d = 2'b00;
    owner_d = owner_q;
    done_d  = 2'b00;
    note_d  = note_q;
    tick_d  = tick_q;
    ms_d    = ms_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = PLAY;
          owner_d = ready_q;
          tick_d  = '0;
          if (ready_q[0]) begin
            note_d = req_note0;
            ms_d   = dur_eff(req_dur0);
          end else begin
            note_d = req_note1;
            ms_d   = dur_eff(req_dur1);
          end
        end else if ((ready_q == 2'b00) && (req_valid != 2'b00)) begin
          ready_d = req_valid[0] ? 2'b01 : 2'b10;
        end
      end
      PLAY, GAP: begin
        if (!tick_end) begin
          tick_d = tick_q + TICK_W'(1);
        end else if (!last_ms) begin
          tick_d = '0;
          ms_d   = ms_q - CNT_W'(1);
        end else if ((state_q == PLAY) && (GAP_MS > 0)) begin
          // Prescaler restarts so the gap length is independent of phase.
          state_d = GAP;
          tick_d  = '0;
          ms_d    = CNT_W'(GAP_MS);
        end else begin
          state_d = IDLE;
          done_d  = owner_q;
          owner_d = 2'b00;
          tick_d  = '0;
          ms_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = 2'b00;
        tick_d  = '0;
        ms_d    = '0;
      end
    endcase
`ifdef SPEAKER_SCHED_PREEMPT_EN
    // Alert aborts a melody note silently; the IDLE path grants it next.
    if ((state_q != IDLE) && owner_q[1] && req_valid[0]) begin
      state_d = IDLE;
      owner_d = 2'b00;
      done_d  = 2'b00;
      tick_d  = '0;
      ms_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk_100mHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 2'b00;
      owner_q <= 2'b00;
      done_q  <= 2'b00;
      note_q  <= '0;
      tick_q  <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      note_q  <= note_d;
      tick_q  <= tick_d;
      ms_q    <= ms_d;
    end
  end

  assign req_ready = ready_q;
  assign note_out  = note_q;
  assign note_on   = (state_q == PLAY) && (note_q != 6'd0);
  assign owner     = owner_q;
  assign done      = done_q;

endmodule

// File: tb/tb_speaker_sched.sv
// Directed bench for speaker_sched with TICK_DIV=4, GAP_MS=2 (1 ms = 4 cycles, gap = 8 cycles).
module tb_speaker_sched;

  localparam int DUR_W = 12;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [5:0]       req_note0, req_note1;
  logic [DUR_W-1:0] req_dur0, req_dur1;
  logic [1:0]       req_ready;
  logic [5:0]       note_out;
  logic             note_on;
  logic [1:0]       owner;
  logic [1:0]       done;

  int total = 0;
  int bad   = 0;

  speaker_sched #(.TICK_DIV(4), .DUR_W(DUR_W), .GAP_MS(2)) dut (
    .clk_100mHz(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_note0(req_note0),
    .req_note1(req_note1),
    .req_dur0(req_dur0),
    .req_dur1(req_dur1),
    .req_ready(req_ready),
    .note_out(note_out),
    .note_on(note_on),
    .owner(owner),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_ready(output logic [1:0] r, output int waited);
    waited = 0;
    while ((req_ready === 2'b00) && (waited < 10)) begin
      @(negedge clk);
      waited++;
    end
    r = req_ready;
  endtask

  // Samples from the current negedge until a done pulse appears (bounded).
  task automatic measure(output int on_cyc, output int cyc, output logic [1:0] done_v,
                         output logic [1:0] own_v, output logic [1:0] rdy_v);
    on_cyc = 0; cyc = 0; done_v = 2'b00; own_v = 2'b11; rdy_v = 2'b11;
    for (int i = 0; i < 20000; i++) begin
      if (done !== 2'b00) begin
        done_v = done; own_v = owner; rdy_v = req_ready;
        return;
      end
      if (note_on === 1'b1) on_cyc++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [1:0] r; int w;
    rst_n = 1'b0; req_valid = 2'b00;
    step();
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", req_ready); end
    total++; if (note_on !== 1'b0) begin bad++; $display("FAIL rst_note_on got=%b want=0", note_on); end
    total++; if (note_out !== 6'd0) begin bad++; $display("FAIL rst_note_out got=%0d want=0", note_out); end
    total++; if (owner !== 2'b00) begin bad++; $display("FAIL rst_owner got=%b want=00", owner); end
    total++; if (done !== 2'b00) begin bad++; $display("FAIL rst_done got=%b want=00", done); end
    req_valid = 2'b01; req_note0 = 6'd7; req_dur0 = 12'd1;
    step();
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_hold_ready got=%b want=00", req_ready); end
    rst_n = 1'b1;
    wait_ready(r, w);
    total++; if (r !== 2'b01 || w != 1) begin bad++; $display("FAIL rst_first_grant got=%b after %0d want=01 after 1", r, w); end
  endtask

  task automatic finish_alert(input logic [5:0] n, input int exp_on, input int exp_cyc);
    int on_c, cyc; logic [1:0] dv, ov, rv;
    step();
    req_valid = 2'b00;
    total++; if (note_out !== n) begin bad++; $display("FAIL alert_note_out got=%0d want=%0d", note_out, n); end
    measure(on_c, cyc, dv, ov, rv);
    total++; if (on_c != exp_on) begin bad++; $display("FAIL alert_on_cycles got=%0d want=%0d", on_c, exp_on); end
    total++; if (cyc != exp_cyc) begin bad++; $display("FAIL alert_len got=%0d want=%0d", cyc, exp_cyc); end
    total++; if (dv !== 2'b01 || ov !== 2'b00) begin bad++; $display("FAIL alert_done got=%b/%b want=01/00", dv, ov); end
    step();
  endtask

  task automatic test_melody();
    logic [1:0] r; int w, on_c, cyc; logic [1:0] dv, ov, rv;
    req_valid = 2'b10; req_note1 = 6'd48; req_dur1 = 12'd3;
    wait_ready(r, w);
    total++; if (r !== 2'b10) begin bad++; $display("FAIL mel_ready got=%b want=10", r); end
    step();
    req_valid = 2'b00;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL mel_ready_one_cycle got=%b want=00", req_ready); end
    total++; if (note_on !== 1'b1 || owner !== 2'b10 || note_out !== 6'd48) begin
      bad++; $display("FAIL mel_start got on=%b own=%b note=%0d want 1/10/48", note_on, owner, note_out); end
    measure(on_c, cyc, dv, ov, rv);
    total++; if (on_c != 12) begin bad++; $display("FAIL mel_on_cycles got=%0d want=12", on_c); end
    total++; if (cyc != 20) begin bad++; $display("FAIL mel_len got=%0d want=20", cyc); end
    total++; if (dv !== 2'b10 || ov !== 2'b00) begin bad++; $display("FAIL mel_done got=%b/%b want=10/00", dv, ov); end
    step();
    total++; if (done !== 2'b00) begin bad++; $display("FAIL mel_done_one_cycle got=%b want=00", done); end
  endtask

  task automatic test_priority();
    logic [1:0] r; int w, on_c, cyc; logic [1:0] dv, ov, rv;
    req_valid = 2'b11; req_note0 = 6'd60; req_dur0 = 12'd1; req_note1 = 6'd50; req_dur1 = 12'd1;
    wait_ready(r, w);
    total++; if (r !== 2'b01) begin bad++; $display("FAIL prio_first got=%b want=01", r); end
    step();
    req_valid = 2'b10;
    measure(on_c, cyc, dv, ov, rv);
    total++; if (dv !== 2'b01 || on_c != 4) begin bad++; $display("FAIL prio_alert got done=%b on=%0d want 01/4", dv, on_c); end
    total++; if (rv !== 2'b00) begin bad++; $display("FAIL prio_ready_in_done got=%b want=00", rv); end
    step();
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL prio_melody_next got=%b want=10", req_ready); end
    step();
    req_valid = 2'b00;
    measure(on_c, cyc, dv, ov, rv);
    total++; if (dv !== 2'b10 || on_c != 4 || cyc != 12) begin
      bad++; $display("FAIL prio_melody got done=%b on=%0d len=%0d want 10/4/12", dv, on_c, cyc); end
    step();
  endtask

  task automatic test_durations();
    logic [1:0] r; int w;
    req_valid = 2'b01; req_note0 = 6'd57; req_dur0 = 12'd0;
    wait_ready(r, w);
    finish_alert(6'd57, 4, 12);
    req_valid = 2'b01; req_note0 = 6'd0; req_dur0 = 12'd2;
    wait_ready(r, w);
    finish_alert(6'd0, 0, 16);
    req_valid = 2'b01; req_note0 = 6'd5; req_dur0 = 12'hFFF;
    wait_ready(r, w);
    finish_alert(6'd5, 16380, 16388);
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; int w, cnt;
    req_valid = 2'b10; req_note1 = 6'd48; req_dur1 = 12'd3;
    wait_ready(r, w);
    step();
    req_valid = 2'b00;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    total++; if (note_on !== 1'b0 || owner !== 2'b00 || done !== 2'b00) begin
      bad++; $display("FAIL rstmid_immediate got on=%b own=%b done=%b want 0/00/00", note_on, owner, done); end
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done !== 2'b00 || note_on !== 1'b0) cnt++;
      step();
    end
    total++; if (cnt != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d active cycles want=0", cnt); end
    req_valid = 2'b01; req_note0 = 6'd20; req_dur0 = 12'd1;
    wait_ready(r, w);
    total++; if (r !== 2'b01 || w != 1) begin bad++; $display("FAIL rstmid_regrant got=%b after %0d want=01 after 1", r, w); end
    finish_alert(6'd20, 4, 12);
  endtask

  task automatic test_preempt();
    logic [1:0] r; int w, on_c, cyc; logic [1:0] dv, ov, rv;
    req_valid = 2'b10; req_note1 = 6'd48; req_dur1 = 12'd3;
    wait_ready(r, w);
    step();
    req_valid = 2'b00;
    repeat (5) step();
    req_valid = 2'b01; req_note0 = 6'd33; req_dur0 = 12'd1;
    step();
`ifdef SPEAKER_SCHED_PREEMPT_EN
    total++; if (note_on !== 1'b0 || owner !== 2'b00 || done !== 2'b00) begin
      bad++; $display("FAIL pre_abort got on=%b own=%b done=%b want 0/00/00", note_on, owner, done); end
    step();
    total++; if (req_ready !== 2'b01 || done !== 2'b00) begin
      bad++; $display("FAIL pre_grant got ready=%b done=%b want 01/00", req_ready, done); end
`else
    total++; if (note_on !== 1'b1 || owner !== 2'b10 || req_ready !== 2'b00) begin
      bad++; $display("FAIL nopre_continue got on=%b own=%b rdy=%b want 1/10/00", note_on, owner, req_ready); end
    measure(on_c, cyc, dv, ov, rv);
    total++; if (dv !== 2'b10 || on_c != 6 || rv !== 2'b00) begin
      bad++; $display("FAIL nopre_melody_done got done=%b on=%0d rdy=%b want 10/6/00", dv, on_c, rv); end
    step();
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL nopre_grant got=%b want=01", req_ready); end
`endif
    finish_alert(6'd33, 4, 12);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00;
    req_note0 = '0; req_note1 = '0; req_dur0 = '0; req_dur1 = '0;
    step();
    test_reset();
    finish_alert(6'd7, 4, 12);
    test_melody();
    test_priority();
    test_durations();
    test_reset_mid();
    test_preempt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
